// File: rtl/tube_pkg.sv
// Shared constants for the multiplexed 7-segment tube driver.
// Glyph patterns are {g,f,e,d,c,b,a}, active-high.
package tube_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_MINUS = 4'hA;

  function automatic logic is_blank_code(
    input logic [3:0] c
  );
    return (c >= 4'hB);
  endfunction

endpackage

// File: rtl/tube_seg_decode.sv
// Combinational code-to-glyph decoder.
// Ports: i_code 4-bit digit code, o_glyph 7-bit {g..a}.
module tube_seg_decode
  import tube_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_glyph
);

  always_comb begin
    o_glyph = SEG_BLANK;
    unique case (i_code)
      4'd0:       o_glyph = SEG_0;
      4'd1:       o_glyph = SEG_1;
      4'd2:       o_glyph = SEG_2;
      4'd3:       o_glyph = SEG_3;
      4'd4:       o_glyph = SEG_4;
      4'd5:       o_glyph = SEG_5;
      4'd6:       o_glyph = SEG_6;
      4'd7:       o_glyph = SEG_7;
      4'd8:       o_glyph = SEG_8;
      4'd9:       o_glyph = SEG_9;
      CODE_MINUS: o_glyph = SEG_MINUS;
      default:    o_glyph = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tube_scan_n.sv
// Multiplexed DIGITS-wide 7-segment driver with frame-synchronous load.
// Ports: clk, rstn, load/data/dp in, blank_lz, bright; seg, sel, frame_done out.
module tube_scan_n
  import tube_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DIV            = 20000,
  parameter int BRIGHT_W       = 3,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = BRIGHT_W + 33;

  localparam logic [7:0] SEG_OFF =
    {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SEL_OFF =
    {DIGITS{SEL_ACTIVE_LOW}};

  logic [CW-1:0]         r_div_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_act;
  logic [DIGITS-1:0]     r_act_dp;
  logic [4*DIGITS-1:0]   r_pend;
  logic [DIGITS-1:0]     r_pend_dp;
  logic                  r_pend_v;
  logic                  r_fd;
  logic [7:0]            r_seg;
  logic [DIGITS-1:0]     r_sel;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic                  w_commit;
  logic [3:0]            w_code;
  logic [6:0]            w_glyph;
  logic [DIGITS-1:0]     w_lz;
  logic [7:0]            w_seg;
  logic [PW-1:0]         w_prod;
  logic [PW-1:0]         w_on;
  logic                  w_sel_en;
  logic [DIGITS-1:0]     w_sel;

  assign w_slot_end  = (r_div_cnt == CW'(DIV - 1));
  assign w_frame_end = w_slot_end &&
                       (r_idx == IW'(DIGITS - 1));
  assign w_commit    = w_frame_end &&
                       (load || r_pend_v);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else begin
      if (w_slot_end) r_div_cnt <= '0;
      else            r_div_cnt <= r_div_cnt + CW'(1);
      if (w_frame_end)     r_idx <= '0;
      else if (w_slot_end) r_idx <= r_idx + IW'(1);
    end
  end

  // A load coinciding with the boundary bypasses the
  // shadow so the newest data is never a frame late.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_act     <= '0;
      r_act_dp  <= '0;
      r_pend    <= '0;
      r_pend_dp <= '0;
      r_pend_v  <= 1'b0;
      r_fd      <= 1'b0;
    end else begin
      r_fd <= w_commit;
      if (w_frame_end) begin
        if (load) begin
          r_act    <= data;
          r_act_dp <= dp;
        end else if (r_pend_v) begin
          r_act    <= r_pend;
          r_act_dp <= r_pend_dp;
        end
        r_pend_v <= 1'b0;
      end else if (load) begin
        r_pend    <= data;
        r_pend_dp <= dp;
        r_pend_v  <= 1'b1;
      end
    end
  end

  // Walk from the most significant digit down; a zero
  // is blanked until a significant code has been seen.
  always_comb begin
    logic [3:0] v_c;
    logic       v_above;
    w_lz    = '0;
    v_above = 1'b0;
    v_c     = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      v_c = r_act[4*k +: 4];
      if (k != 0 && blank_lz &&
          v_c == 4'd0 && !v_above)
        w_lz[k] = 1'b1;
      if (v_c != 4'd0 && !is_blank_code(v_c))
        v_above = 1'b1;
    end
  end

  assign w_code = r_act[4*int'(r_idx) +: 4];

  tube_seg_decode u_dec (
    .i_code  (w_code),
    .o_glyph (w_glyph)
  );

  assign w_seg = {r_act_dp[r_idx],
                  w_lz[r_idx] ? SEG_BLANK : w_glyph};

  assign w_prod = (PW'(bright) + PW'(1)) * PW'(DIV);
  assign w_on   = w_prod >> BRIGHT_W;

  assign w_sel_en = (PW'(r_div_cnt) < w_on);
  assign w_sel    = w_sel_en ?
                    (DIGITS'(1) << r_idx) : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_seg <= SEG_OFF;
      r_sel <= SEL_OFF;
    end else begin
      r_seg <= w_seg ^ SEG_OFF;
      r_sel <= w_sel ^ SEL_OFF;
    end
  end

  assign seg        = r_seg;
  assign sel        = r_sel;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_tube_scan_n.sv
// Self-checking bench for tube_scan_n: vector table plus
// a per-cycle scoreboard on the main DIV=4 instance.
module tb_tube_scan_n;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic        blz = 1'b0;
  logic [2:0]  bright = 3'd7;
  logic [2:0]  bright_b = 3'd7;

  logic [7:0]  seg_a, seg_b, seg_c;
  logic [3:0]  sel_a, sel_b, sel_c;
  logic        fd_a, fd_b, fd_c;

  always #5 clk = ~clk;

  tube_scan_n #(
    .DIGITS(4), .DIV(4), .BRIGHT_W(3),
    .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)
  ) u_a (
    .clk(clk), .rstn(rstn), .load(load),
    .data(data), .dp(dp), .blank_lz(blz),
    .bright(bright), .seg(seg_a), .sel(sel_a),
    .frame_done(fd_a)
  );

  tube_scan_n #(
    .DIGITS(4), .DIV(8), .BRIGHT_W(3),
    .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)
  ) u_b (
    .clk(clk), .rstn(rstn), .load(1'b0),
    .data(16'h0), .dp(4'h0), .blank_lz(1'b0),
    .bright(bright_b), .seg(seg_b), .sel(sel_b),
    .frame_done(fd_b)
  );

  tube_scan_n #(
    .DIGITS(4), .DIV(8), .BRIGHT_W(3),
    .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) u_c (
    .clk(clk), .rstn(rstn), .load(1'b0),
    .data(16'h0), .dp(4'h0), .blank_lz(1'b0),
    .bright(bright_b), .seg(seg_c), .sel(sel_c),
    .frame_done(fd_c)
  );

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] sel;
    logic       fd;
  } exp_t;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        blz;
    logic [31:0] seg;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [6:0] gl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
    7'h07, 7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00,
    7'h00, 7'h00
  };

  logic [3:0]  m_act [4];
  logic [3:0]  m_adp;
  logic [15:0] m_pend;
  logic [3:0]  m_pdp;
  logic        m_pv;
  int          m_div;
  int          m_idx;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_act[i] = '0;
    m_adp  = '0;
    m_pend = '0;
    m_pdp  = '0;
    m_pv   = 1'b0;
    m_div  = 0;
    m_idx  = 0;
  endfunction

  function automatic exp_t model_out();
    exp_t       e;
    logic [3:0] c;
    logic       bl;
    int         on;
    c  = m_act[m_idx];
    bl = 1'b0;
    if (blz && m_idx > 0 && c == 4'd0) begin
      bl = 1'b1;
      for (int j = m_idx + 1; j < 4; j++)
        if (m_act[j] != 4'd0 && m_act[j] < 4'd11)
          bl = 1'b0;
    end
    e.seg = {m_adp[m_idx], bl ? 7'h00 : gl[c]};
    on    = ((int'(bright) + 1) * 4) / 8;
    e.sel = (m_div < on) ? (4'b0001 << m_idx) : 4'h0;
    e.fd  = (m_div == 3 && m_idx == 3) &&
            (load || m_pv);
    return e;
  endfunction

  function automatic void model_step();
    if (m_div == 3 && m_idx == 3) begin
      if (load) begin
        for (int i = 0; i < 4; i++)
          m_act[i] = data[4*i +: 4];
        m_adp = dp;
      end else if (m_pv) begin
        for (int i = 0; i < 4; i++)
          m_act[i] = m_pend[4*i +: 4];
        m_adp = m_pdp;
      end
      m_pv = 1'b0;
    end else if (load) begin
      m_pend = data;
      m_pdp  = dp;
      m_pv   = 1'b1;
    end
    if (m_div == 3) begin
      m_div = 0;
      m_idx = (m_idx + 1) % 4;
    end else begin
      m_div++;
    end
  endfunction

  task automatic tick();
    exp_t e;
    if (!rstn) begin
      model_reset();
      e = '0;
    end else begin
      e = model_out();
      model_step();
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_seg", 32'(seg_a), 32'(e.seg));
    chk("sb_sel", 32'(sel_a), 32'(e.sel));
    chk("sb_fd",  32'(fd_a),  32'(e.fd));
  endtask

  task automatic load_wait(output logic seen);
    load = 1'b1;
    tick();
    load = 1'b0;
    seen = fd_a;
    for (int t = 0; t < 64 && !seen; t++) begin
      tick();
      if (fd_a) seen = 1'b1;
    end
  endtask

  vec_t vt [8];

  initial begin
    logic       seen;
    logic [7:0] segs [4];
    int         cnt [4];
    int         fdc, cb, cc, bad, bad5, old_bad;
    logic [7:0] new7;
    logic       got7;

    vt[0] = '{16'h1234, 4'h0, 1'b0, 32'h065B4F66};
    vt[1] = '{16'h00A3, 4'h0, 1'b1, 32'h0000404F};
    vt[2] = '{16'h0000, 4'h0, 1'b1, 32'h0000003F};
    vt[3] = '{16'hF000, 4'h4, 1'b1, 32'h0080003F};
    vt[4] = '{16'h1000, 4'h0, 1'b1, 32'h063F3F3F};
    vt[5] = '{16'h0A00, 4'h9, 1'b1, 32'h80403FBF};
    vt[6] = '{16'h9876, 4'h0, 1'b0, 32'h6F7F077D};
    vt[7] = '{16'h50B0, 4'h0, 1'b1, 32'h6D3F003F};

    model_reset();
    #2 rstn = 1'b0;
    #1;
    chk("rst_seg_a", 32'(seg_a), 32'h00);
    chk("rst_sel_a", 32'(sel_a), 32'h0);
    chk("rst_fd_a",  32'(fd_a),  32'h0);
    chk("rst_seg_c", 32'(seg_c), 32'hFF);
    chk("rst_sel_c", 32'(sel_c), 32'hF);
    tick();
    tick();
    #2 rstn = 1'b1;

    foreach (vt[v]) begin
      data = vt[v].data;
      dp   = vt[v].dp;
      blz  = vt[v].blz;
      load_wait(seen);
      chk("fd_seen", 32'(seen), 32'h1);
      for (int k = 0; k < 4; k++) begin
        segs[k] = 8'hEE;
        cnt[k]  = 0;
      end
      fdc = 0;
      for (int t = 0; t < 16; t++) begin
        tick();
        if (fd_a) fdc++;
        for (int k = 0; k < 4; k++)
          if (sel_a == (4'b0001 << k)) begin
            segs[k] = seg_a;
            cnt[k]++;
          end
      end
      for (int k = 0; k < 4; k++) begin
        chk("vec_seg", 32'(segs[k]),
            32'(vt[v].seg[8*k +: 8]));
        chk("slot_len", 32'(cnt[k]), 32'd4);
      end
      chk("fd_once", 32'(fdc), 32'd0);
    end

    blz  = 1'b0;
    dp   = 4'h0;
    data = 16'h1234;
    load_wait(seen);
    chk("sh_sync", 32'(seen), 32'h1);
    for (int t = 0; t < 5; t++) tick();
    data = 16'h0005;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int t = 0; t < 3; t++) tick();
    data = 16'h0007;
    load = 1'b1;
    tick();
    load = 1'b0;
    bad5 = 0; old_bad = 0; fdc = 0;
    got7 = 1'b0; new7 = 8'hEE;
    for (int t = 0; t < 24; t++) begin
      tick();
      if (sel_a == 4'b0001) begin
        if (seg_a == 8'h6D) bad5++;
        if (fdc == 0 && seg_a != 8'h66) old_bad++;
        if (fdc != 0 && !got7) begin
          new7 = seg_a;
          got7 = 1'b1;
        end
      end
      if (fd_a) fdc++;
    end
    chk("sh_no5",    32'(bad5),    32'd0);
    chk("sh_hold",   32'(old_bad), 32'd0);
    chk("sh_new7",   32'(new7),    32'h07);
    chk("sh_fd_cnt", 32'(fdc),     32'd1);

    for (int p = 0; p < 3; p++) begin
      bright_b = (p == 0) ? 3'd0 :
                 (p == 1) ? 3'd3 : 3'd7;
      tick();
      tick();
      cb = 0; cc = 0; bad = 0;
      for (int t = 0; t < 32; t++) begin
        tick();
        if (sel_b != 4'h0) begin
          cb++;
          if (!$onehot(sel_b)) bad++;
        end
        if (sel_c != 4'hF) begin
          cc++;
          if (!$onehot(~sel_c)) bad++;
        end
        if (seg_b != 8'h3F) bad++;
        if (seg_c != 8'hC0) bad++;
      end
      chk("bright_b", 32'(cb), (p == 0) ? 32'd4 :
                      (p == 1) ? 32'd16 : 32'd32);
      chk("bright_c", 32'(cc), (p == 0) ? 32'd4 :
                      (p == 1) ? 32'd16 : 32'd32);
      chk("bright_shape", 32'(bad), 32'd0);
    end

    seen = 1'b0;
    for (int t = 0; t < 32 && !seen; t++) begin
      tick();
      if (sel_a == 4'b0010) seen = 1'b1;
    end
    chk("rst_sync", 32'(seen), 32'h1);
    data = 16'h0005;
    load = 1'b1;
    tick();
    load = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("arst_seg_a", 32'(seg_a), 32'h00);
    chk("arst_sel_a", 32'(sel_a), 32'h0);
    chk("arst_seg_c", 32'(seg_c), 32'hFF);
    chk("arst_sel_c", 32'(sel_c), 32'hF);
    sb.delete();
    model_reset();
    tick();
    tick();
    #2 rstn = 1'b1;
    tick();
    chk("rel_sel", 32'(sel_a), 32'h1);
    chk("rel_seg", 32'(seg_a), 32'h3F);
    fdc = 0; bad5 = 0;
    for (int t = 0; t < 32; t++) begin
      tick();
      if (fd_a) fdc++;
      if (seg_a == 8'h6D) bad5++;
    end
    chk("rel_no_fd", 32'(fdc),  32'd0);
    chk("rel_no5",   32'(bad5), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
